// File: rtl/mixer_pkg.sv
// Shared constants and the 16-bit saturation helper for the voice mixer
// and any later stage that narrows a wide accumulator to a sample.
package mixer_pkg;

  localparam int SAMPLE_W = 16;
  localparam int IDX_W    = 8;
  // Widest accumulator sat16 accepts; callers sign-extend into it.
  localparam int SAT_IN_W = 64;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  // Clamp a wide signed value to the signed 16-bit sample range.
  function automatic logic signed [SAMPLE_W-1:0] sat16(input logic signed [SAT_IN_W-1:0] x);
    if (x > SAT_IN_W'(SAMPLE_MAX)) begin
      return SAMPLE_MAX;
    end else if (x < SAT_IN_W'(SAMPLE_MIN)) begin
      return SAMPLE_MIN;
    end else begin
      return x[SAMPLE_W-1:0];
    end
  endfunction

endpackage

// File: rtl/voice_mixer_if.sv
// Voice strobe input and mixed-sample valid/ready output of the mixer.
// master: the environment (envelope stage + serializer); slave: the mixer.
interface voice_mixer_if;
  import mixer_pkg::*;

  logic [IDX_W-1:0]           voice_index;
  logic signed [SAMPLE_W-1:0] voice_sample;
  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] out_sample;
  logic                       out_valid;
  logic                       out_ready;

  modport master (
    output voice_index, voice_sample, sample_valid, out_ready,
    input  out_sample, out_valid
  );

  modport slave (
    input  voice_index, voice_sample, sample_valid, out_ready,
    output out_sample, out_valid
  );
endinterface

// File: rtl/sat_shift.sv
// Combinational arithmetic (floor) right shift followed by 16-bit clamp.
module sat_shift
  import mixer_pkg::*;
#(
  parameter int ACC_WIDTH = 24,
  parameter int SHIFT     = 5
) (
  input  logic signed [ACC_WIDTH-1:0] acc_i,
  output logic signed [SAMPLE_W-1:0]  sample_o
);

  logic signed [ACC_WIDTH-1:0] shifted;

  assign shifted  = acc_i >>> SHIFT;
  assign sample_o = sat16(SAT_IN_W'(shifted));

endmodule

// File: rtl/voice_mixer.sv
// Sums one enveloped sample per voice into a mono frame, scales and
// saturates it, and holds it for the serializer on a valid/ready port.
// Sticky flags report frame sequencing errors and output overruns.
module voice_mixer
  import mixer_pkg::*;
#(
  parameter int NUM_VOICES = 32,
  parameter int ACC_WIDTH  = 24,
  parameter int SHIFT      = 5
) (
  input  logic          clk,
  input  logic          reset,
  voice_mixer_if.slave  bus,
  input  logic          clear_flags,
  output logic          seq_error,
  output logic          overrun
);

  // One spare bit so a count of NUM_VOICES is representable.
  localparam int CNT_W = IDX_W + 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_VOICES - 1);

  logic signed [ACC_WIDTH-1:0] acc_q, acc_d, acc_base, total;
  logic [CNT_W-1:0]            cnt_q, cnt_d, cnt_base;
  logic [IDX_W-1:0]            expect_q, expect_d;
  logic signed [SAMPLE_W-1:0]  out_sample_q, out_sample_d, mixed;
  logic                        out_valid_q, out_valid_d;
  logic                        seq_error_q, seq_error_d;
  logic                        overrun_q, overrun_d;
  logic                        strobe, is_first, is_close;

  // Out-of-range indices are dropped before they touch any state.
  assign strobe   = bus.sample_valid && (int'(bus.voice_index) < NUM_VOICES);
  assign is_first = (bus.voice_index == '0);
  assign is_close = (int'(bus.voice_index) == NUM_VOICES - 1);

  // Index 0 restarts the sum, so a single-voice frame totals just its sample.
  assign acc_base = is_first ? '0 : acc_q;
  assign cnt_base = is_first ? '0 : cnt_q;
  assign total    = acc_base + ACC_WIDTH'(bus.voice_sample);

  sat_shift #(
    .ACC_WIDTH (ACC_WIDTH),
    .SHIFT     (SHIFT)
  ) u_sat_shift (
    .acc_i    (total),
    .sample_o (mixed)
  );

  // Next-state: accumulate, check ordering, close frames, run the handshake.
  always_comb begin
    // NOTE: every target gets a default first, so no path leaves a latch.
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    expect_d     = expect_q;
    out_sample_d = out_sample_q;
    out_valid_d  = out_valid_q && !bus.out_ready;
    seq_error_d  = seq_error_q && !clear_flags;
    overrun_d    = overrun_q && !clear_flags;

    if (strobe) begin
      if (is_first && cnt_q != '0) seq_error_d = 1'b1;
      if (!is_first && bus.voice_index != expect_q) seq_error_d = 1'b1;

      if (is_close) begin
        out_sample_d = mixed;
        out_valid_d  = 1'b1;
        if (out_valid_q && !bus.out_ready) overrun_d = 1'b1;
        if (cnt_base != LAST_CNT) seq_error_d = 1'b1;
        acc_d    = '0;
        cnt_d    = '0;
        expect_d = '0;
      end else begin
        acc_d    = total;
        // Saturate so a long run of strobes without a close cannot wrap.
        cnt_d    = (cnt_base == '1) ? cnt_base : cnt_base + CNT_W'(1);
        expect_d = bus.voice_index + IDX_W'(1);
      end
    end
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (!reset) begin
      acc_q        <= '0;
      cnt_q        <= '0;
      expect_q     <= '0;
      out_sample_q <= '0;
      out_valid_q  <= 1'b0;
      seq_error_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      expect_q     <= expect_d;
      out_sample_q <= out_sample_d;
      out_valid_q  <= out_valid_d;
      seq_error_q  <= seq_error_d;
      overrun_q    <= overrun_d;
    end
  end

  assign bus.out_sample = out_sample_q;
  assign bus.out_valid  = out_valid_q;
  assign seq_error      = seq_error_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_voice_mixer.sv
// Directed bench for voice_mixer: two instances (SHIFT=5 and SHIFT=0) see
// identical stimulus; expected outputs are hand-computed constants.
module tb_voice_mixer;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic clear_flags = 1'b0;
  logic seq5, ovr5, seq0, ovr0;
  int   checks = 0;
  int   failures = 0;

  voice_mixer_if bus5 ();
  voice_mixer_if bus0 ();

  voice_mixer #(.NUM_VOICES(32), .ACC_WIDTH(24), .SHIFT(5)) dut5 (
    .clk(clk), .reset(rst), .bus(bus5), .clear_flags(clear_flags),
    .seq_error(seq5), .overrun(ovr5)
  );

  voice_mixer #(.NUM_VOICES(32), .ACC_WIDTH(24), .SHIFT(0)) dut0 (
    .clk(clk), .reset(rst), .bus(bus0), .clear_flags(clear_flags),
    .seq_error(seq0), .overrun(ovr0)
  );

  always #5 clk = ~clk;

  typedef struct {
    string name;
    int    s0;      // sample for voice 0
    int    srest;   // sample for voices 1..31
    int    skip;    // voice index left out, -1 for none
    int    exp5;    // expected out_sample at SHIFT=5
    int    exp0;    // expected out_sample at SHIFT=0
    bit    exp_seq;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic signed [31:0] act,
                       input logic signed [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic drive_ready(input logic r);
    bus5.out_ready = r;
    bus0.out_ready = r;
  endtask

  // One strobe lasting one cycle; returns 1 time unit after the sampling edge.
  task automatic strobe(input int idx, input int s, input logic clr = 1'b0);
    bus5.voice_index = 8'(idx);   bus0.voice_index = 8'(idx);
    bus5.voice_sample = 16'(s);   bus0.voice_sample = 16'(s);
    bus5.sample_valid = 1'b1;     bus0.sample_valid = 1'b1;
    clear_flags = clr;
    @(posedge clk); #1;
    bus5.sample_valid = 1'b0;     bus0.sample_valid = 1'b0;
    clear_flags = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Full frame; an out-of-range index 99 strobe is slipped in after voice 7.
  task automatic run_frame(input int s0, input int srest, input int skip,
                           input logic clr_at_close = 1'b0);
    for (int v = 0; v < 32; v++) begin
      if (v != skip) strobe(v, (v == 0) ? s0 : srest, (v == 31) ? clr_at_close : 1'b0);
      if (v == 7) strobe(99, 12345);
    end
  endtask

  task automatic pulse_clear();
    clear_flags = 1'b1;
    @(posedge clk); #1;
    clear_flags = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
  endtask

  initial begin
    vecs[0] = '{"sum_1000",   1000,   1000,   -1, 1000,   32000,  1'b0};
    vecs[1] = '{"sat_pos",    32767,  32767,  -1, 32767,  32767,  1'b0};
    vecs[2] = '{"sat_neg",    -32768, -32768, -1, -32768, -32768, 1'b0};
    vecs[3] = '{"neg_floor",  -1,     0,      -1, -1,     -1,     1'b0};
    vecs[4] = '{"mixed_neg",  -100,   3,      -1, -1,     -7,     1'b0};
    vecs[5] = '{"mixed_pos",  32767,  -1,     -1, 1023,   32736,  1'b0};
    vecs[6] = '{"skip5",      100,    100,    5,  96,     3100,   1'b1};
    vecs[7] = '{"clean_64",   64,     64,     -1, 64,     2048,   1'b0};

    bus5.voice_index = '0;  bus0.voice_index = '0;
    bus5.voice_sample = '0; bus0.voice_sample = '0;
    bus5.sample_valid = 1'b0; bus0.sample_valid = 1'b0;
    drive_ready(1'b1);
    do_reset();

    check("reset_out_sample", bus5.out_sample, 0);
    check("reset_out_valid",  bus5.out_valid, 0);
    check("reset_seq_error",  seq5, 0);
    check("reset_overrun",    ovr5, 0);

    // Table-driven frames with the consumer always ready.
    foreach (vecs[i]) begin
      run_frame(vecs[i].s0, vecs[i].srest, vecs[i].skip);
      check({vecs[i].name, "_out5"},  bus5.out_sample, vecs[i].exp5);
      check({vecs[i].name, "_out0"},  bus0.out_sample, vecs[i].exp0);
      check({vecs[i].name, "_valid"}, bus5.out_valid, 1);
      check({vecs[i].name, "_seq5"},  seq5, vecs[i].exp_seq);
      check({vecs[i].name, "_seq0"},  seq0, vecs[i].exp_seq);
      check({vecs[i].name, "_ovr"},   ovr5, 0);
      idle(1);
      check({vecs[i].name, "_valid_drop"}, bus5.out_valid, 0);
      check({vecs[i].name, "_hold5"}, bus5.out_sample, vecs[i].exp5);
      pulse_clear();
      check({vecs[i].name, "_seq_cleared"}, seq5, 0);
    end

    // clear_flags on the same edge as a mis-sequenced close: set wins.
    run_frame(100, 100, 5, 1'b1);
    check("clr_vs_set_seq", seq5, 1);
    pulse_clear();
    check("clr_vs_set_cleared", seq5, 0);

    // Overrun: two frames closed with no consumer.
    drive_ready(1'b0);
    run_frame(100, 100, -1);
    check("ovr_first_out5",  bus5.out_sample, 100);
    check("ovr_first_valid", bus5.out_valid, 1);
    check("ovr_first_flag",  ovr5, 0);
    idle(3);
    check("ovr_stall_stable", bus5.out_sample, 100);
    run_frame(200, 200, -1);
    check("ovr_second_out5", bus5.out_sample, 200);
    check("ovr_second_out0", bus0.out_sample, 6400);
    check("ovr_second_valid", bus5.out_valid, 1);
    check("ovr_flag5", ovr5, 1);
    check("ovr_flag0", ovr0, 1);
    check("ovr_no_seq", seq5, 0);
    idle(1);
    check("ovr_flag_sticky", ovr5, 1);
    drive_ready(1'b1);
    idle(1);
    check("ovr_drain_valid", bus5.out_valid, 0);
    pulse_clear();
    check("ovr_cleared", ovr5, 0);

    // Reset with a pending sample and a partial frame in flight.
    drive_ready(1'b0);
    run_frame(300, 300, -1);
    check("pre_reset_pending", bus5.out_valid, 1);
    for (int v = 0; v <= 10; v++) strobe(v, 500);
    do_reset();
    check("mid_reset_valid",  bus5.out_valid, 0);
    check("mid_reset_sample", bus5.out_sample, 0);
    drive_ready(1'b1);
    run_frame(64, 64, -1);
    check("post_reset_out5", bus5.out_sample, 64);
    check("post_reset_out0", bus0.out_sample, 2048);
    check("post_reset_seq",  seq5, 0);
    check("post_reset_ovr",  ovr5, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/voice_mixer.md
# voice_mixer

Downstream stage of the per-voice ADSR envelope stage. Accumulates the stream of enveloped voice samples, one per voice per frame, into a single signed mono sample. Scales and saturates the sum, then presents it on a valid/ready interface to the DAC/I2S serializer. Flags sequencing errors and output overruns.

## Interface
- NUM_VOICES, 32: voices per frame; valid indices are 0..NUM_VOICES-1.
- ACC_WIDTH, 24: accumulator width. Must be ≥ 16 + clog2(NUM_VOICES).
- SHIFT, 5: arithmetic right shift applied to the frame sum before saturation.

- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-low; sampled on rising clk.
- voice_index  in  8  voice number of the current sample; the same index driven to the envelope stage.
- voice_sample  in  16  signed enveloped sample (envelope stage output_sample).
- sample_valid  in  1  qualifies voice_index/voice_sample for one cycle.
- out_sample  out  16  signed mixed sample.
- out_valid  out  1  out_sample holds an unconsumed frame.
- out_ready  in  1  consumer accepts out_sample when out_valid && out_ready.
- clear_flags  in  1  clears the sticky flags.
- seq_error  out  1  sticky: a frame closed with voice count ≠ NUM_VOICES, or indices arrived out of order.
- overrun  out  1  sticky: a frame completed while the previous frame was still unconsumed.

## Operation
- The accumulator `acc` (signed ACC_WIDTH), voice counter `cnt` and `expect` (next expected index) update only on sample_valid.
- A strobe with voice_index ≥ NUM_VOICES is ignored entirely: no acc, cnt or flag change.
- voice_index == 0 starts a new frame:
  - acc ← sext(voice_sample); cnt ← 1; expect ← 1.
  - If cnt ≠ 0 here (the previous frame never closed), set seq_error.
- Other valid index:
  - acc ← acc + sext(voice_sample); cnt ← cnt+1; expect ← voice_index+1.
  - If voice_index ≠ expect, set seq_error. The sample is still added.
- voice_index == NUM_VOICES-1 closes the frame:
  - total = acc + sext(voice_sample). For NUM_VOICES == 1, index 0 both opens and closes, and total = sext(voice_sample).
  - out_sample ← sat16(total >>> SHIFT). The shift is arithmetic (floor). sat16 clamps to [-32768, 32767].
  - out_valid ← 1.
  - If cnt+1 ≠ NUM_VOICES, set seq_error.
  - acc, cnt, expect ← 0.
- Handshake:
  - out_valid clears on the cycle after out_valid && out_ready, unless a frame closes in that same cycle.
  - out_sample stays stable while out_valid && !out_ready, except on overrun.
- Overrun: a frame closes while out_valid && !out_ready. The newest frame overwrites out_sample, out_valid stays 1, and overrun is set.
- A close coinciding with out_valid && out_ready is not an overrun: the new value loads and out_valid stays 1.
- clear_flags clears seq_error and overrun. If it coincides with a setting event, the set wins.

## Timing
- Reset values: out_sample 0, out_valid 0, seq_error 0, overrun 0. Internal acc, cnt, expect also 0.
- Latency: out_sample/out_valid update on the clk edge that samples the closing strobe, so they are visible one cycle after it.
- Input strobes may arrive every cycle. The envelope stage currently delivers one every 2 cycles. There is no back-pressure on the input side.
- Reset asserted mid-frame discards the partial sum and any pending out_sample. After reset the mixer waits for the next index 0. Strobes with a non-zero index before then accumulate and will raise seq_error at close.
- Flags are registered: they assert one cycle after the causing strobe and hold until cleared.

## Structure
- mixer_pkg: SAMPLE_W = 16, SAMPLE_MAX/SAMPLE_MIN constants, function sat16 (ACC_WIDTH input → 16-bit clamp).
- One sub-module: sat_shift (parameters ACC_WIDTH, SHIFT; combinational arithmetic shift + clamp). It is reused by the future stereo pan stage.
- Top level: accumulator/sequence-checker datapath plus the output register and handshake.

## Test plan
- Basic sum: 32 strobes, all samples +1000, out_ready=1 → out_sample = 32000>>5 = 1000, out_valid pulses one cycle, no flags.
- Saturation, SHIFT=0:
  - Positive: all 32 samples +32767 → out_sample = 32767.
  - Negative: all samples -32768 → -32768.
- Negative floor: voice 0 = -1, others 0, SHIFT=5 → out_sample = -1 (not 0).
- Sequence error:
  - Index 5 skipped → seq_error=1 one cycle after close; out_sample still = sum of 31 samples >>> 5.
  - clear_flags → 0.
- Overrun: out_ready=0 across two full frames (sums 3200, 6400) → out_sample=200 after the second close, overrun=1, out_valid=1. Then out_ready=1 → out_valid=0 next cycle.
- Reset mid-frame: reset after voice 10; then a clean frame of +64 ×32 → out_sample=64, no flags. Index 99 strobes are ignored throughout.
